// File: rtl/ls259_writer.sv
// Serialises masked byte updates into single-bit writes on an ls259 addressable latch
// and keeps a shadow copy of the latch. Define LS259_SKIP_UNCHANGED_EN to skip bits already matching the shadow.
`timescale 1ns/1ps
module ls259_writer #(
  parameter int unsigned SETUP_CYCLES  = 1,
  parameter int unsigned STROBE_CYCLES = 2
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       req_valid,
  output logic       req_ready,
  input  logic       req_clear,
  input  logic [7:0] req_data,
  input  logic [7:0] req_mask,
  output logic [2:0] S,
  output logic       D,
  output logic       En_b,
  output logic       clr_b,
  output logic       busy,
  output logic       done,
  output logic [7:0] shadow
);

  localparam int unsigned CntMax = (SETUP_CYCLES > STROBE_CYCLES) ? SETUP_CYCLES : STROBE_CYCLES;
  localparam int unsigned CntW   = $clog2(CntMax + 1);
  localparam logic [CntW-1:0] SetupLast  = CntW'(SETUP_CYCLES - 1);
  localparam logic [CntW-1:0] StrobeLast = CntW'(STROBE_CYCLES - 1);

  typedef enum logic [2:0] {
    StIdle, StSetup, StStrobe, StHold, StClear, StFinish
  } state_e;

  state_e          state_q, state_d;
  logic [CntW-1:0] cnt_q, cnt_d;
  logic [2:0]      idx_q, idx_d;
  logic [7:0]      pend_q, pend_d;
  logic [7:0]      data_q, data_d;
  logic [7:0]      shadow_q, shadow_d;
  logic [2:0]      s_q, s_d;
  logic            d_q, d_d;
  logic            en_b_q, en_b_d;
  logic            clr_b_q, clr_b_d;
  logic            done_q, done_d;
  logic [7:0]      eff_mask;
  logic [2:0]      nxt_idx;

  function automatic logic [2:0] lowest_bit(input logic [7:0] m);
    logic [2:0] r;
    r = '0;
    for (int i = 7; i >= 0; i--) begin
      if (m[i]) r = 3'(i);
    end
    return r;
  endfunction

`ifdef LS259_SKIP_UNCHANGED_EN
  assign eff_mask = req_mask & (req_data ^ shadow_q);
`else
  assign eff_mask = req_mask;
`endif

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    idx_d    = idx_q;
    pend_d   = pend_q;
    data_d   = data_q;
    shadow_d = shadow_q;
    s_d      = s_q;
    d_d      = d_q;
    nxt_idx  = '0;

    case (state_q)
      StIdle: begin
        if (req_valid) begin
          data_d = req_data;
          cnt_d  = '0;
          if (req_clear) begin
            state_d = StClear;
          end else if (eff_mask == 8'h00) begin
            state_d = StFinish;
          end else begin
            nxt_idx = lowest_bit(eff_mask);
            state_d = StSetup;
            idx_d   = nxt_idx;
            pend_d  = eff_mask & ~(8'h01 << nxt_idx);
          end
        end
      end
      StSetup: begin
        if (cnt_q == SetupLast) begin
          state_d = StStrobe;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + CntW'(1);
        end
      end
      StStrobe: begin
        if (cnt_q == StrobeLast) begin
          state_d = StHold;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + CntW'(1);
        end
      end
      StHold: begin
        // The latch has captured the bit by the end of the hold cycle.
        shadow_d[idx_q] = data_q[idx_q];
        if (pend_q != 8'h00) begin
          nxt_idx = lowest_bit(pend_q);
          state_d = StSetup;
          idx_d   = nxt_idx;
          pend_d  = pend_q & ~(8'h01 << nxt_idx);
        end else begin
          state_d = StFinish;
        end
      end
      StClear: begin
        if (cnt_q == StrobeLast) begin
          state_d  = StFinish;
          cnt_d    = '0;
          shadow_d = 8'h00;
        end else begin
          cnt_d = cnt_q + CntW'(1);
        end
      end
      StFinish: state_d = StIdle;
      default:  state_d = StIdle;
    endcase

    // Pins are registered from the next state so they never glitch.
    en_b_d  = (state_d != StStrobe);
    clr_b_d = (state_d != StClear);
    done_d  = (state_d == StFinish);
    if (state_d == StSetup) begin
      s_d = idx_d;
      d_d = data_d[idx_d];
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= StIdle;
      cnt_q    <= '0;
      idx_q    <= '0;
      pend_q   <= '0;
      data_q   <= '0;
      shadow_q <= '0;
      s_q      <= '0;
      d_q      <= 1'b0;
      en_b_q   <= 1'b1;
      clr_b_q  <= 1'b1;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      idx_q    <= idx_d;
      pend_q   <= pend_d;
      data_q   <= data_d;
      shadow_q <= shadow_d;
      s_q      <= s_d;
      d_q      <= d_d;
      en_b_q   <= en_b_d;
      clr_b_q  <= clr_b_d;
      done_q   <= done_d;
    end
  end

  assign req_ready = (state_q == StIdle);
  assign busy      = (state_q != StIdle);
  assign S         = s_q;
  assign D         = d_q;
  assign En_b      = en_b_q;
  assign clr_b     = clr_b_q;
  assign done      = done_q;
  assign shadow    = shadow_q;

endmodule

// File: tb/tb_ls259_writer.sv
// Scoreboard bench for ls259_writer: directed requests queue expected bus cycles and
// completions; a negedge monitor checks pins, strobe timing and done against them.
`timescale 1ns/1ps
module tb_ls259_writer;

  localparam int unsigned SetupC  = 1;
  localparam int unsigned StrobeC = 2;

  logic       clk = 1'b0;
  logic       rst;
  logic       req_valid, req_ready, req_clear;
  logic [7:0] req_data, req_mask;
  logic [2:0] S;
  logic       D, En_b, clr_b, busy, done;
  logic [7:0] shadow;

  always #5 clk = ~clk;

  ls259_writer #(
    .SETUP_CYCLES (SetupC),
    .STROBE_CYCLES(StrobeC)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .req_valid(req_valid),
    .req_ready(req_ready),
    .req_clear(req_clear),
    .req_data (req_data),
    .req_mask (req_mask),
    .S        (S),
    .D        (D),
    .En_b     (En_b),
    .clr_b    (clr_b),
    .busy     (busy),
    .done     (done),
    .shadow   (shadow)
  );

  typedef struct packed {
    logic       clr;
    logic [2:0] s;
    logic       d;
  } bus_t;

  typedef struct packed {
    logic [7:0]  shadow;
    logic [31:0] lat;
  } resp_t;

  bus_t        wr_q[$];
  resp_t       exp_q[$];
  int unsigned n_cmp = 0;
  int unsigned n_bad = 0;
  int unsigned cyc = 0;
  int unsigned accept_cyc = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, want 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Bus and completion monitor
  logic        prev_en = 1'b1, prev_clr = 1'b1, prev_d = 1'b0, st_d = 1'b0;
  logic [2:0]  prev_s = '0, st_s = '0;
  int unsigned en_len = 0, clr_len = 0;

  always @(negedge clk) begin
    bus_t  e;
    resp_t r;
    if (rst) begin
      prev_en  = 1'b1;
      prev_clr = 1'b1;
      en_len   = 0;
      clr_len  = 0;
    end else begin
      chk("en_clr_exclusive", 32'(En_b | clr_b), 32'd1);
      if (req_valid && req_ready) accept_cyc = cyc;

      if (!En_b && prev_en) begin
        chk("setup_s_stable", 32'(S), 32'(prev_s));
        chk("setup_d_stable", 32'(D), 32'(prev_d));
        en_len = 1;
        st_s   = S;
        st_d   = D;
        chk("write_expected", 32'(wr_q.size() != 0), 32'd1);
        if (wr_q.size() != 0) begin
          e = wr_q.pop_front();
          chk("write_kind", 32'(e.clr), 32'd0);
          chk("write_addr", 32'(S), 32'(e.s));
          chk("write_data", 32'(D), 32'(e.d));
        end
      end else if (!En_b) begin
        en_len++;
      end
      if (En_b && !prev_en) begin
        chk("strobe_len", en_len, StrobeC);
        chk("hold_s", 32'(S), 32'(st_s));
        chk("hold_d", 32'(D), 32'(st_d));
      end

      if (!clr_b && prev_clr) begin
        clr_len = 1;
        chk("clear_expected", 32'(wr_q.size() != 0), 32'd1);
        if (wr_q.size() != 0) begin
          e = wr_q.pop_front();
          chk("clear_kind", 32'(e.clr), 32'd1);
        end
      end else if (!clr_b) begin
        clr_len++;
      end
      if (clr_b && !prev_clr) chk("clear_len", clr_len, StrobeC);

      if (done) begin
        chk("done_expected", 32'(exp_q.size() != 0), 32'd1);
        if (exp_q.size() != 0) begin
          r = exp_q.pop_front();
          chk("done_shadow", 32'(shadow), 32'(r.shadow));
          chk("done_latency", cyc - accept_cyc, r.lat);
          chk("writes_drained", 32'(wr_q.size()), 32'd0);
        end
      end
      prev_en  = En_b;
      prev_clr = clr_b;
      prev_s   = S;
      prev_d   = D;
    end
  end

  task automatic push_bits(input logic [7:0] data, input logic [7:0] mask);
    for (int i = 0; i < 8; i++) begin
      if (mask[i]) wr_q.push_back('{clr: 1'b0, s: 3'(i), d: data[i]});
    end
  endtask

  task automatic send(input logic clr, input logic [7:0] data, input logic [7:0] mask);
    int unsigned k;
    k = 0;
    while (!req_ready && k < 200) begin
      @(negedge clk);
      k++;
    end
    chk("ready_before_send", 32'(req_ready), 32'd1);
    @(posedge clk);
    #1;
    req_valid = 1'b1;
    req_clear = clr;
    req_data  = data;
    req_mask  = mask;
    @(posedge clk);
    #1;
    // Post-accept changes must be ignored.
    req_valid = 1'b0;
    req_clear = ~clr;
    req_data  = ~data;
    req_mask  = ~mask;
  endtask

  task automatic issue(input logic clr, input logic [7:0] data, input logic [7:0] mask,
                       input logic [7:0] exp_sh, input int unsigned lat);
    logic got;
    exp_q.push_back('{shadow: exp_sh, lat: lat});
    send(clr, data, mask);
    got = 1'b0;
    for (int i = 0; i < int'(lat) + 20 && !got; i++) begin
      @(negedge clk);
      if (done) got = 1'b1;
    end
    chk("done_seen", 32'(got), 32'd1);
    @(negedge clk);
    chk("done_one_cycle", 32'(done), 32'd0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    logic found;
    rst       = 1'b1;
    req_valid = 1'b0;
    req_clear = 1'b0;
    req_data  = 8'h00;
    req_mask  = 8'h00;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;

    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("rst_en_b", 32'(En_b), 32'd1);
      chk("rst_clr_b", 32'(clr_b), 32'd1);
      chk("rst_ready", 32'(req_ready), 32'd1);
      chk("rst_busy", 32'(busy), 32'd0);
      chk("rst_shadow", 32'(shadow), 32'h00);
      chk("rst_done", 32'(done), 32'd0);
    end

    // Full byte write
    push_bits(8'hA5, 8'hFF);
    issue(1'b0, 8'hA5, 8'hFF, 8'hA5, 33);

    // Rewrite of identical contents
`ifdef LS259_SKIP_UNCHANGED_EN
    issue(1'b0, 8'hA5, 8'hFF, 8'hA5, 1);
`else
    push_bits(8'hA5, 8'hFF);
    issue(1'b0, 8'hA5, 8'hFF, 8'hA5, 33);
`endif

    // Partial mask: bits 2 and 3 to zero (bit 3 already zero)
`ifdef LS259_SKIP_UNCHANGED_EN
    push_bits(8'h00, 8'h04);
    issue(1'b0, 8'h00, 8'h0C, 8'hA1, 5);
`else
    push_bits(8'h00, 8'h0C);
    issue(1'b0, 8'h00, 8'h0C, 8'hA1, 9);
`endif

    // Clear overrides data and mask
    wr_q.push_back('{clr: 1'b1, s: 3'd0, d: 1'b0});
    issue(1'b1, 8'hFF, 8'hFF, 8'h00, 3);

    // Empty mask completes with no bus activity
    issue(1'b0, 8'hFF, 8'h00, 8'h00, 1);

    // Abort by reset during the strobe of bit 4
    push_bits(8'hFF, 8'hFF);
    send(1'b0, 8'hFF, 8'hFF);
    found = 1'b0;
    for (int i = 0; i < 100 && !found; i++) begin
      @(negedge clk);
      if (!En_b && S == 3'd4) found = 1'b1;
    end
    chk("reached_bit4_strobe", 32'(found), 32'd1);
    chk("shadow_before_abort", 32'(shadow), 32'h0F);
    #1;
    rst = 1'b1;
    #1;
    chk("abort_en_b", 32'(En_b), 32'd1);
    chk("abort_clr_b", 32'(clr_b), 32'd1);
    chk("abort_ready", 32'(req_ready), 32'd1);
    chk("abort_busy", 32'(busy), 32'd0);
    chk("abort_done", 32'(done), 32'd0);
    chk("abort_shadow", 32'(shadow), 32'h00);
    wr_q.delete();
    exp_q.delete();
    repeat (3) @(negedge clk);
    @(posedge clk);
    #1;
    rst = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      chk("post_abort_no_done", 32'(done), 32'd0);
    end

    // Normal request after the abort
    push_bits(8'hF0, 8'hF0);
    issue(1'b0, 8'hF0, 8'hF0, 8'hF0, 17);

    repeat (3) @(negedge clk);
    chk("final_writes_left", 32'(wr_q.size()), 32'd0);
    chk("final_dones_left", 32'(exp_q.size()), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
